inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Command fetcher directly downstream of the async instruction BRAM. Drives its two async read
//  addresses, parses the command words (header + operands) and streams them as ready/valid beats
//  to the geometry/state pipeline. Runs from START_ADDR until it accepts a FLUSH or reaches MEM_DEPTH.
//  Header word: [31] has-operands, [15:8] operand count (imm arg if [31]=0), [7:0] opcode.
// PARAMETERS
//  START_ADDR  0      word address of the first command
//  MEM_DEPTH   50     words in the BRAM; no read or advance at or beyond this address
//  FLUSH_OP    8'h05  opcode that ends the command list
// PORTS
//  clk        in   1    clock; all state changes on posedge
//  rst        in   1    synchronous, active-high reset
//  start      in   1    1-cycle pulse; begins fetch (ignored unless IDLE or DONE)
//  addr1      out  32   BRAM header read address (= pc)
//  addr2      out  32   BRAM operand read address (= pc)
//  read0      in   32   mem[addr1], combinational
//  read1..4   in   32   mem[addr2+0..3], combinational
//  out_valid  out  1    output beat valid
//  out_ready  in   1    downstream accepts beat
//  out_hdr    out  1    1 = header beat, 0 = operand beat
//  out_data   out  128  hdr: [31:0]=header word; ops: word k at [32k+31:32k]; unused words = 0
//  out_nwords out  3    valid words in beat (hdr:1, ops:1..4)
//  out_last   out  1    last beat of this command
//  busy       out  1    state != IDLE and != DONE
//  done       out  1    state == DONE and out_valid == 0
//  err        out  1    sticky: operands truncated at MEM_DEPTH; cleared by rst/start
// BEHAVIOUR
//  Reset: state IDLE, pc=START_ADDR, out_valid/out_hdr/out_last/busy/done/err=0, out_data=0, out_nwords=0.
//  Output register loads when slot free: load_en = !out_valid | out_ready; pc advances only on load.
//  IDLE: on start -> HDR, pc=START_ADDR, err=0. DONE: on start restarts identically.
//  HDR (load_en): if pc>=MEM_DEPTH -> DONE, no beat. read0==0 -> NOP: pc+1, no beat, 1 cycle each.
//   else load header beat; last=!([31] && count>0); pc+1;
//   [31]&&count>0 -> OPS, rem=count; else opcode==FLUSH_OP -> DONE; else stay HDR.
//  OPS (load_en): n=min(rem,4,MEM_DEPTH-pc); load operand beat (n words, read1..),
//   rem-=n, pc+=n; last=(rem==n). If n==0 or n<min(rem,4): err=1, last=1, -> DONE.
//   rem reaches 0 -> HDR (or DONE if pc>=MEM_DEPTH).
//  Count 0 with [31]=1: header only, last=1. rem is 8-bit; counts up to 255 legal.
//  Latency: start at edge E0 -> HDR; first header beat valid after E1. Full rate: 1 beat/cycle.
//  Backpressure: out_valid && !out_ready holds out_* and pc/addr1/addr2 stable; no word skipped/duplicated.
//  out_valid drops only after accept with nothing loaded; beat pending at DONE entry is still delivered.
//  rst mid-command: next cycle out_valid=0, IDLE, pending beat discarded.
//  start while busy: ignored. BRAM must not be written while busy.
// TESTING
//  1. mem[0..3]=80000304,3F800000,0,0; start -> hdr beat data 80000304 nwords 1 last 0; then ops beat
//     nwords 3, words 3F800000,0,0, last 1.
//  2. mem[0]=80001011 + 16 operands -> hdr + 4 ops beats of 4 words, last only on 4th; pc=17 after.
//  3. Case 2 with out_ready low 5 cycles on 2nd ops beat -> out_data/addr2 stable, all 16 words in order.
//  4. mem[0..1]=0, mem[2]=00000110, mem[3]=00000005 -> beats: hdr 00000110 last 1, hdr 00000005 last 1;
//     done=1 after accept, addr1 stays 4.
//  5. MEM_DEPTH=50, mem[47]=80000304 -> ops beat nwords 2, last 1, err=1, done=1.
//  6. rst during OPS of case 2 -> next cycle out_valid=0, busy=0; start then replays from mem[0].

Source files
------------

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_unit
// Brief   : Walks the command BRAM from START_ADDR, splits each command into
//           a header beat and up to four-word operand beats on a ready/valid
//           output, and stops on FLUSH_OP or at MEM_DEPTH.
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned MEM_DEPTH  = 50,
   parameter logic [7:0]  FLUSH_OP   = 8'h05
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [31:0]  addr1,
   output logic [31:0]  addr2,
   input  logic [31:0]  read0,
   input  logic [31:0]  read1,
   input  logic [31:0]  read2,
   input  logic [31:0]  read3,
   input  logic [31:0]  read4,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_hdr,
   output logic [127:0] out_data,
   output logic [2:0]   out_nwords,
   output logic         out_last,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam logic [31:0] C_START = 32'(START_ADDR);
   localparam logic [31:0] C_DEPTH = 32'(MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_OPS  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   pc;
   logic [31:0]   pc_nxt;
   logic [7:0]    rem;
   logic [7:0]    rem_nxt;
   logic          err_nxt;
   logic          load_en;

   logic          beat_load;
   logic          beat_hdr;
   logic          beat_last;
   logic [127:0]  beat_data;
   logic [2:0]    beat_nwords;

   logic [31:0]   ops_word [4];
   logic [31:0]   avail;
   logic [2:0]    want;
   logic [2:0]    n;
   logic [7:0]    rem_left;
   logic [31:0]   pc_ops;

   assign addr1   = pc;
   assign addr2   = pc;
   assign busy    = (state == S_HDR) || (state == S_OPS);
   assign done    = (state == S_DONE) && !out_valid;
   assign load_en = !out_valid || out_ready;

   assign ops_word[0] = read1;
   assign ops_word[1] = read2;
   assign ops_word[2] = read3;
   assign ops_word[3] = read4;

   // Words in this operand beat: bounded by what remains, the beat width and the end of memory
   assign avail    = (pc >= C_DEPTH) ? 32'd0 : (C_DEPTH - pc);
   assign want     = (rem >= 8'd4) ? 3'd4 : rem[2:0];
   assign n        = (avail < {29'd0, want}) ? avail[2:0] : want;
   assign rem_left = rem - {5'd0, n};
   assign pc_ops   = pc + {29'd0, n};

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      rem_nxt     = rem;
      err_nxt     = err;
      beat_load   = 1'b0;
      beat_hdr    = 1'b0;
      beat_last   = 1'b0;
      beat_data   = '0;
      beat_nwords = 3'd0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_HDR;
               pc_nxt    = C_START;
               err_nxt   = 1'b0;
            end
         end

         S_HDR: begin
            if (load_en) begin
               if (pc >= C_DEPTH) begin
                  state_nxt = S_DONE;
               end else if (read0 == 32'd0) begin
                  pc_nxt = pc + 32'd1;
               end else begin
                  beat_load        = 1'b1;
                  beat_hdr         = 1'b1;
                  beat_nwords      = 3'd1;
                  beat_data[31:0]  = read0;
                  pc_nxt           = pc + 32'd1;
                  if (read0[31] && (read0[15:8] != 8'd0)) begin
                     state_nxt = S_OPS;
                     rem_nxt   = read0[15:8];
                     beat_last = 1'b0;
                  end else begin
                     beat_last = 1'b1;
                     if (read0[7:0] == FLUSH_OP) begin
                        state_nxt = S_DONE;
                     end
                  end
               end
            end
         end

         S_OPS: begin
            if (load_en) begin
               beat_load   = 1'b1;
               beat_nwords = n;
               pc_nxt      = pc_ops;
               rem_nxt     = rem_left;
               for (int k = 0; k < 4; k++) begin
                  if (3'(k) < n) begin
                     beat_data[32*k +: 32] = ops_word[k];
                  end
               end
               // Memory ran out before the operand count was satisfied
               if (n < want) begin
                  err_nxt   = 1'b1;
                  beat_last = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  beat_last = (rem_left == 8'd0);
                  if (rem_left == 8'd0) begin
                     state_nxt = (pc_ops >= C_DEPTH) ? S_DONE : S_HDR;
                  end
               end
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= C_START;
         rem        <= 8'd0;
         err        <= 1'b0;
         out_valid  <= 1'b0;
         out_hdr    <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         out_nwords <= 3'd0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         rem   <= rem_nxt;
         err   <= err_nxt;
         if (load_en) begin
            out_valid <= beat_load;
            if (beat_load) begin
               out_hdr    <= beat_hdr;
               out_last   <= beat_last;
               out_data   <= beat_data;
               out_nwords <= beat_nwords;
            end
         end
      end
   end

endmodule
`default_nettype wire
